// File: rtl/serial_defs.sv
// Shared definitions for the serial pattern-detector path: serializer state
// encodings and parameter defaults.
package serial_defs;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } ser_state_t;

    localparam bit IDLE_BIT_DEFAULT  = 1'b0;
    localparam bit LSB_FIRST_DEFAULT = 1'b1;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-word holding register with a full flag; lets the next word wait while
// the current one is still shifting out.
module bit_serializer_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            full <= 1'b0;
        end else if (wr) begin
            q    <= d;
            full <= 1'b1;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock on dout, streaming back-to-back words without a gap.
module bit_serializer
    import serial_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = LSB_FIRST_DEFAULT,
    parameter bit IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_shifted;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic             accept;
    logic             last_bit;
    logic             hold_wr;
    logic             hold_rd;

    // Handshake: a word transfers on a rising edge where din_valid && din_ready.
    // din_ready is forced low during reset and otherwise mirrors hold space.
    assign din_ready = rst & ~hold_full;
    assign accept    = din_valid & din_ready;
    assign last_bit  = (state == S_SHIFT) && (cnt == LAST);

    // Mid-word accepts park in hold; a last-bit accept with hold empty bypasses it.
    assign hold_wr = accept && (state == S_SHIFT) && !last_bit;
    assign hold_rd = last_bit && hold_full;

    assign sh_shifted = LSB_FIRST ? (sh >> 1) : (sh << 1);

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .wr   (hold_wr),
        .rd   (hold_rd),
        .d    (din),
        .q    (hold_q),
        .full (hold_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sh    <= din;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != LAST) begin
                        sh  <= sh_shifted;
                        cnt <= cnt + CW'(1);
                    end else if (hold_full) begin
                        sh  <= hold_q;
                        cnt <= '0;
                    end else if (accept) begin
                        sh  <= din;
                        cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // dout depends only on sh and state, never directly on din.
    always_comb begin
        dout       = IDLE_BIT;
        dout_valid = 1'b0;
        if (state == S_SHIFT) begin
            dout       = LSB_FIRST ? sh[0] : sh[WIDTH-1];
            dout_valid = 1'b1;
        end
    end

    assign busy = (state == S_SHIFT) | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed vector table, hand-written
// corner sequences, and random traffic against a bit-queue reference model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         dout;
    logic         dout_valid;
    logic         busy;

    logic [W-1:0] din2;
    logic         din2_valid;
    logic         din2_ready;
    logic         dout2;
    logic         dout2_valid;
    logic         busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .din_valid  (din2_valid),
        .din_ready  (din2_ready),
        .dout       (dout2),
        .dout_valid (dout2_valid),
        .busy       (busy2)
    );

    typedef struct {
        logic         vld;
        logic [W-1:0] d;
        logic         e_dout;
        logic         e_dv;
        logic         e_rdy;
        logic         e_busy;
    } vec_t;

    vec_t vecs[$];
    logic exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic vld, input logic [W-1:0] d, input logic e_dout,
                           input logic e_dv, input logic e_rdy, input logic e_busy);
        vec_t v;
        v.vld = vld; v.d = d; v.e_dout = e_dout;
        v.e_dv = e_dv; v.e_rdy = e_rdy; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] w2;
        logic         model_rdy;
        logic         acc;
        logic         pending;
        int           dv_seen;

        // Single word 0xA5.
        w = 8'hA5;
        add_vec(1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) add_vec(1'b0, '0, w[i], 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Back-to-back 0xF0 then 0x0F; second word waits in hold.
        w = 8'hF0; w2 = 8'h0F;
        add_vec(1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(1'b1, w2, w[0], 1'b1, 1'b1, 1'b1);
        for (int i = 1; i < W; i++) add_vec(1'b0, '0, w[i], 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < W; i++) add_vec(1'b0, '0, w2[i], 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        // 0x3C offered exactly on the last bit of 0x01 bypasses hold.
        w = 8'h01; w2 = 8'h3C;
        add_vec(1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W - 1; i++) add_vec(1'b0, '0, w[i], 1'b1, 1'b1, 1'b1);
        add_vec(1'b1, w2, w[W-1], 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < W; i++) add_vec(1'b0, '0, w2[i], 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset held with din_valid high.
        rst = 1'b0; din_valid = 1'b1; din = 8'h55;
        din2_valid = 1'b0; din2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_msb_dout_idle", dout2, 1);
        rst = 1'b1;
        #1;
        check("release_din_ready", din_ready, 1);
        tick();
        check("first_edge_accept_dv", dout_valid, 1);
        check("first_edge_accept_bit0", dout, 1);
        din_valid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("drain_busy", busy, 0);

        // Vector table.
        foreach (vecs[k]) begin
            din_valid = vecs[k].vld;
            din = vecs[k].d;
            @(negedge clk);
            check($sformatf("vec%0d_dout", k), dout, vecs[k].e_dout);
            check($sformatf("vec%0d_dout_valid", k), dout_valid, vecs[k].e_dv);
            check($sformatf("vec%0d_din_ready", k), din_ready, vecs[k].e_rdy);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].e_busy);
            tick();
        end
        din_valid = 1'b0;

        // Reset during bit 3 of 0xFF with 0xAA pending.
        din_valid = 1'b1; din = 8'hFF;
        tick();
        din = 8'hAA;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        check("midrst_pre_dout", dout, 1);
        check("midrst_pre_busy", busy, 1);
        check("midrst_pre_ready", din_ready, 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_async_dout", dout, 0);
        check("midrst_async_dv", dout_valid, 0);
        check("midrst_async_busy", busy, 0);
        check("midrst_async_ready", din_ready, 0);
        #2 rst = 1'b1;
        dv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dout_valid) dv_seen++;
        end
        check("midrst_no_replay", dv_seen, 0);

        // MSB-first instance with idle level 1.
        w = 8'h80;
        din2_valid = 1'b1; din2 = w;
        tick();
        din2_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("msb_bit%0d", i), dout2, w[W-1-i]);
            check($sformatf("msb_dv%0d", i), dout2_valid, 1);
            tick();
        end
        check("msb_idle_dout", dout2, 1);
        check("msb_idle_dv", dout2_valid, 0);
        check("msb_idle_busy", busy2, 0);

        // Random traffic vs. bit-queue model: the queue holds every bit not yet
        // shown; the block has room for another word while at most one word's
        // worth of bits remains.
        exp_q.delete();
        pending = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!pending) begin
                din_valid = ($urandom_range(0, 3) != 0);
                din = W'($urandom);
            end
            @(negedge clk);
            model_rdy = (exp_q.size() <= W);
            check("rnd_din_ready", din_ready, model_rdy);
            check("rnd_busy", busy, exp_q.size() > 0);
            check("rnd_dout_valid", dout_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("rnd_dout", dout, exp_q[0]);
            else check("rnd_dout_idle", dout, 0);
            acc = din_valid && model_rdy;
            @(posedge clk);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) for (int i = 0; i < W; i++) exp_q.push_back(din[i]);
            #1;
            pending = din_valid && !acc;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
